hbridge_driver: RTL and testbench



---
 rtl/hbridge_pkg.sv | 21 ++
 rtl/hbridge_channel.sv | 171 +++++++++++++++++
 rtl/hbridge_driver.sv | 65 ++++++
 tb/tb_hbridge_driver.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/hbridge_pkg.sv
// Shared types and direction codes for the dual H-bridge driver.
// Used by hbridge_channel and hbridge_driver.
package hbridge_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'b00,
    ST_RUN   = 2'b01,
    ST_BRAKE = 2'b10,
    ST_DEAD  = 2'b11
  } ch_state_e;

  localparam logic [1:0] DIR_COAST = 2'b00;
  localparam logic [1:0] DIR_A     = 2'b01;
  localparam logic [1:0] DIR_B     = 2'b10;
  localparam logic [1:0] DIR_BRAKE = 2'b11;

  function automatic logic is_drive(input logic [1:0] code);
    return (code == DIR_A) || (code == DIR_B);
  endfunction

endpackage

// File: rtl/hbridge_channel.sv
// One motor channel: state machine, dead-time counter, duty register and ramp.
// HBRIDGE_RAMP_EN selects the soft-start ramp; otherwise duty is fixed at DUTY_MAX.
module hbridge_channel
  import hbridge_pkg::*;
#(
  parameter int PWM_W       = 8,
  parameter int DUTY_MIN    = 64,
  parameter int DUTY_MAX    = 200,
  parameter int RAMP_STEP   = 8,
  parameter int DEAD_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       cmd,
  input  logic             en,
  input  logic [PWM_W-1:0] pwm_cnt,
  output logic [1:0]       br_in,
  output logic             br_en,
  output logic             dead
);

  localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [DW-1:0]    DEAD_LOAD = DW'(DEAD_CYCLES - 1);
  localparam logic [DW-1:0]    DEAD_ZERO = {DW{1'b0}};
  localparam logic [PWM_W-1:0] DUTY_TOP  = PWM_W'(DUTY_MAX);

  // Empty on purpose: only an illegal parameter set elaborates this scope.
  if ((DUTY_MIN > DUTY_MAX) || (DUTY_MAX >= (1 << PWM_W)) || (RAMP_STEP < 0) ||
      (DEAD_CYCLES < 1)) begin : g_cfg_illegal
  end

  ch_state_e        state_r, state_nxt_s;
  logic [1:0]       last_dir_r, last_dir_nxt_s;
  logic [DW-1:0]    dead_cnt_r, dead_cnt_nxt_s;
  logic [PWM_W-1:0] duty_r, duty_nxt_s;
  logic             run_entry_s;

  // Next-state, direction memory and dead-time countdown.
  always_comb begin
    state_nxt_s    = state_r;
    last_dir_nxt_s = last_dir_r;
    dead_cnt_nxt_s = dead_cnt_r;
    case (state_r)
      ST_OFF: begin
        if (en && is_drive(cmd)) begin
          if ((last_dir_r == DIR_COAST) || (last_dir_r == cmd)) begin
            state_nxt_s    = ST_RUN;
            last_dir_nxt_s = cmd;
          end else begin
            state_nxt_s    = ST_DEAD;
            dead_cnt_nxt_s = DEAD_LOAD;
          end
        end else if (en && (cmd == DIR_BRAKE)) begin
          state_nxt_s = ST_BRAKE;
        end else begin
          state_nxt_s = ST_OFF;
        end
      end
      ST_RUN: begin
        if (!en || (cmd == DIR_COAST)) begin
          state_nxt_s = ST_OFF;
        end else if (cmd == DIR_BRAKE) begin
          state_nxt_s = ST_BRAKE;
        end else if (cmd != last_dir_r) begin
          state_nxt_s    = ST_DEAD;
          dead_cnt_nxt_s = DEAD_LOAD;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_BRAKE: begin
        if (!en || (cmd == DIR_COAST)) begin
          state_nxt_s = ST_OFF;
        end else if (is_drive(cmd)) begin
          state_nxt_s    = ST_RUN;
          last_dir_nxt_s = cmd;
        end else begin
          state_nxt_s = ST_BRAKE;
        end
      end
      ST_DEAD: begin
        // Dead time always runs to completion unless the channel is disabled.
        if (!en) begin
          state_nxt_s = ST_OFF;
        end else if (dead_cnt_r != DEAD_ZERO) begin
          dead_cnt_nxt_s = dead_cnt_r - {{(DW-1){1'b0}}, 1'b1};
        end else if (is_drive(cmd)) begin
          state_nxt_s    = ST_RUN;
          last_dir_nxt_s = cmd;
        end else if (cmd == DIR_BRAKE) begin
          state_nxt_s = ST_BRAKE;
        end else begin
          state_nxt_s = ST_OFF;
        end
      end
      default: begin
        state_nxt_s = ST_OFF;
      end
    endcase
  end

  assign run_entry_s = (state_nxt_s == ST_RUN) && (state_r != ST_RUN);

`ifdef HBRIDGE_RAMP_EN
  localparam logic [PWM_W:0] DUTY_CEIL = (PWM_W+1)'(DUTY_MAX);
  localparam logic [PWM_W:0] STEP_W    = (PWM_W+1)'(RAMP_STEP);
  logic [PWM_W:0] duty_sum_s;

  // Soft-start: restart at DUTY_MIN, then step once per PWM period up to the ceiling.
  always_comb begin
    duty_sum_s = {1'b0, duty_r} + STEP_W;
    if (run_entry_s) begin
      duty_nxt_s = PWM_W'(DUTY_MIN);
    end else if ((state_r == ST_RUN) && (pwm_cnt == {PWM_W{1'b1}})) begin
      duty_nxt_s = (duty_sum_s > DUTY_CEIL) ? DUTY_TOP : duty_sum_s[PWM_W-1:0];
    end else begin
      duty_nxt_s = duty_r;
    end
  end
`else
  // Fixed duty: full DUTY_MAX from the first period.
  always_comb begin
    if (run_entry_s) begin
      duty_nxt_s = DUTY_TOP;
    end else begin
      duty_nxt_s = duty_r;
    end
  end
`endif

  // State registers and registered bridge pins for the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_OFF;
      last_dir_r <= DIR_COAST;
      dead_cnt_r <= DEAD_ZERO;
      duty_r     <= {PWM_W{1'b0}};
      br_in      <= DIR_COAST;
      br_en      <= 1'b0;
      dead       <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      last_dir_r <= last_dir_nxt_s;
      dead_cnt_r <= dead_cnt_nxt_s;
      duty_r     <= duty_nxt_s;
      case (state_nxt_s)
        ST_RUN: begin
          br_in <= last_dir_nxt_s;
          br_en <= (pwm_cnt < duty_nxt_s);
          dead  <= 1'b0;
        end
        ST_BRAKE: begin
          br_in <= DIR_BRAKE;
          br_en <= 1'b1;
          dead  <= 1'b0;
        end
        ST_DEAD: begin
          br_in <= DIR_COAST;
          br_en <= 1'b0;
          dead  <= 1'b1;
        end
        default: begin
          br_in <= DIR_COAST;
          br_en <= 1'b0;
          dead  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/hbridge_driver.sv
// Dual H-bridge driver top: input synchronizers, shared PWM counter, two channels.
// Define HBRIDGE_RAMP_EN to build the soft-start duty ramp.
module hbridge_driver
  import hbridge_pkg::*;
#(
  parameter int PWM_W       = 8,
  parameter int DUTY_MIN    = 64,
  parameter int DUTY_MAX    = 200,
  parameter int RAMP_STEP   = 8,
  parameter int DEAD_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] motor_in,
  input  logic [1:0] motor_en,
  output logic [3:0] br_in,
  output logic [1:0] br_en,
  output logic [1:0] dead
);

  logic [3:0]       in_meta_r, in_sync_r;
  logic [1:0]       en_meta_r, en_sync_r;
  logic [PWM_W-1:0] pwm_cnt_r;

  // Two-flop synchronizers for the unclocked command inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_meta_r <= 4'b0000;
      in_sync_r <= 4'b0000;
      en_meta_r <= 2'b00;
      en_sync_r <= 2'b00;
    end else begin
      in_meta_r <= motor_in;
      in_sync_r <= in_meta_r;
      en_meta_r <= motor_en;
      en_sync_r <= en_meta_r;
    end
  end

  // Free-running PWM counter shared by both channels; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_r <= {PWM_W{1'b0}};
    end else begin
      pwm_cnt_r <= pwm_cnt_r + {{(PWM_W-1){1'b0}}, 1'b1};
    end
  end

  hbridge_channel #(
    .PWM_W(PWM_W), .DUTY_MIN(DUTY_MIN), .DUTY_MAX(DUTY_MAX),
    .RAMP_STEP(RAMP_STEP), .DEAD_CYCLES(DEAD_CYCLES)
  ) u_left (
    .clk(clk), .rst_n(rst_n), .cmd(in_sync_r[3:2]), .en(en_sync_r[1]),
    .pwm_cnt(pwm_cnt_r), .br_in(br_in[3:2]), .br_en(br_en[1]), .dead(dead[1])
  );

  hbridge_channel #(
    .PWM_W(PWM_W), .DUTY_MIN(DUTY_MIN), .DUTY_MAX(DUTY_MAX),
    .RAMP_STEP(RAMP_STEP), .DEAD_CYCLES(DEAD_CYCLES)
  ) u_right (
    .clk(clk), .rst_n(rst_n), .cmd(in_sync_r[1:0]), .en(en_sync_r[0]),
    .pwm_cnt(pwm_cnt_r), .br_in(br_in[1:0]), .br_en(br_en[0]), .dead(dead[0])
  );

endmodule

// File: tb/tb_hbridge_driver.sv
// Self-checking bench for hbridge_driver: behavioural per-cycle model plus directed
// literal checks, followed by randomized command sequences.
`timescale 1ns/1ps
module tb_hbridge_driver;

  localparam int DMIN = 64;
  localparam int DMAX = 200;
  localparam int STEP = 8;
  localparam int DC   = 1000;
  localparam int MD_OFF = 0, MD_RUN = 1, MD_BRAKE = 2, MD_DEAD = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] motor_in = 4'b0000;
  logic [1:0] motor_en = 2'b00;
  logic [3:0] br_in;
  logic [1:0] br_en;
  logic [1:0] dead;

  int checks = 0;
  int failures = 0;

  hbridge_driver #(
    .PWM_W(8), .DUTY_MIN(DMIN), .DUTY_MAX(DMAX), .RAMP_STEP(STEP), .DEAD_CYCLES(DC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .motor_in(motor_in), .motor_en(motor_en),
    .br_in(br_in), .br_en(br_en), .dead(dead)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode per motor, clocks spent in dead time, PWM periods since RUN entry
  int         m_mode [2];
  logic [1:0] m_dir  [2];
  int         m_ds   [2];
  int         m_k    [2];
  logic [3:0] in_d1, in_d2;
  logic [1:0] en_d1, en_d2;
  int         pwm_m, edges;
  logic [3:0] exp_br_in;
  logic [1:0] exp_br_en, exp_dead;

  function automatic int duty_after(input int k);
`ifdef HBRIDGE_RAMP_EN
    int d;
    d = DMIN + STEP * k;
    return (d > DMAX) ? DMAX : d;
`else
    return (k >= 0) ? DMAX : DMAX;
`endif
  endfunction

  task automatic model_channel(input int ch, input logic [1:0] c, input logic e, input int p);
    int   prev;
    logic drv;
    prev = m_mode[ch];
    drv  = (c == 2'b01) || (c == 2'b10);
    case (prev)
      MD_OFF: begin
        if (e && drv) begin
          if (m_dir[ch] == 2'b00 || m_dir[ch] == c) begin m_mode[ch] = MD_RUN; m_dir[ch] = c; end
          else begin m_mode[ch] = MD_DEAD; m_ds[ch] = 0; end
        end else if (e && c == 2'b11) m_mode[ch] = MD_BRAKE;
      end
      MD_RUN: begin
        if (!e || c == 2'b00) m_mode[ch] = MD_OFF;
        else if (c == 2'b11) m_mode[ch] = MD_BRAKE;
        else if (c != m_dir[ch]) begin m_mode[ch] = MD_DEAD; m_ds[ch] = 0; end
      end
      MD_BRAKE: begin
        if (!e || c == 2'b00) m_mode[ch] = MD_OFF;
        else if (drv) begin m_mode[ch] = MD_RUN; m_dir[ch] = c; end
      end
      default: begin
        if (!e) m_mode[ch] = MD_OFF;
        else begin
          m_ds[ch]++;
          if (m_ds[ch] == DC) begin
            if (drv) begin m_mode[ch] = MD_RUN; m_dir[ch] = c; end
            else if (c == 2'b11) m_mode[ch] = MD_BRAKE;
            else m_mode[ch] = MD_OFF;
          end
        end
      end
    endcase
    if (m_mode[ch] == MD_RUN) begin
      if (prev != MD_RUN) m_k[ch] = 0;
      else if (p == 255) m_k[ch]++;
    end
    case (m_mode[ch])
      MD_RUN:   begin exp_br_in[ch*2 +: 2] = m_dir[ch]; exp_br_en[ch] = (p < duty_after(m_k[ch])); exp_dead[ch] = 1'b0; end
      MD_BRAKE: begin exp_br_in[ch*2 +: 2] = 2'b11; exp_br_en[ch] = 1'b1; exp_dead[ch] = 1'b0; end
      MD_DEAD:  begin exp_br_in[ch*2 +: 2] = 2'b00; exp_br_en[ch] = 1'b0; exp_dead[ch] = 1'b1; end
      default:  begin exp_br_in[ch*2 +: 2] = 2'b00; exp_br_en[ch] = 1'b0; exp_dead[ch] = 1'b0; end
    endcase
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int ch = 0; ch < 2; ch++) begin
          m_mode[ch] = MD_OFF; m_dir[ch] = 2'b00; m_ds[ch] = 0; m_k[ch] = 0;
        end
        in_d1 = 4'b0000; in_d2 = 4'b0000; en_d1 = 2'b00; en_d2 = 2'b00;
        pwm_m = 0; edges = 0;
        exp_br_in = 4'b0000; exp_br_en = 2'b00; exp_dead = 2'b00;
      end else begin
        model_channel(1, in_d2[3:2], en_d2[1], pwm_m);
        model_channel(0, in_d2[1:0], en_d2[0], pwm_m);
        in_d2 = in_d1; in_d1 = motor_in;
        en_d2 = en_d1; en_d1 = motor_en;
        pwm_m = (pwm_m + 1) % 256;
        edges++;
      end
    end
  end

  // Per-cycle comparison against the model, sampled on the inactive edge
  initial begin
    forever begin
      @(negedge clk);
      checks++;
      if ({br_in, br_en, dead} !== {exp_br_in, exp_br_en, exp_dead}) begin
        failures++;
        $display("FAIL model_cycle t=%0t actual br_in=%b br_en=%b dead=%b required br_in=%b br_en=%b dead=%b",
                 $time, br_in, br_en, dead, exp_br_in, exp_br_en, exp_dead);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Measures left dead time after a reversal command; optionally re-commands mid-dead.
  task automatic measure_left_dead(input int ret_after, input logic [3:0] ret_cmd,
                                   output int len, output int coast);
    int guard;
    guard = 0; len = 0; coast = 0;
    while (!dead[1] && guard < 20) begin @(negedge clk); guard++; end
    while (dead[1] && len < 3000) begin
      len++;
      if (br_in[3:2] == 2'b00) coast++;
      if (len == ret_after) motor_in = ret_cmd;
      @(negedge clk);
    end
  endtask

  initial begin
    int hi, len, coast, seen, n;
    repeat (3) @(negedge clk);
    check("reset_outputs", {24'd0, br_in, br_en, dead}, 32'd0);

    // First start: 3-clock latency, no dead time
    @(negedge clk);
    rst_n = 1'b1; motor_en = 2'b11; motor_in = 4'b0101;
    repeat (2) @(negedge clk);
    check("latency_before", {28'd0, br_in}, 32'd0);
    @(negedge clk);
    check("latency_at3", {28'd0, br_in}, 32'd5);

    // Second full PWM period after release: edges 257..512
    while (edges < 256) @(negedge clk);
    hi = 0;
    for (int i = 0; i < 256; i++) begin @(negedge clk); hi += int'(br_en[0]); end
`ifdef HBRIDGE_RAMP_EN
    check("period1_high", hi, 72);
`else
    check("period1_high", hi, 200);
`endif

    // Left reversal 01 -> 10
    @(negedge clk); motor_in = 4'b1001;
    measure_left_dead(0, 4'b1001, len, coast);
    check("dead_len_rev", len, DC);
    check("dead_coast_rev", coast, DC);
    check("dir_after_rev", {30'd0, br_in[3:2]}, 32'd2);

    // Reversal 10 -> 01 that returns to 10 mid-dead: dead time not shortened
    @(negedge clk); motor_in = 4'b0101;
    measure_left_dead(100, 4'b1001, len, coast);
    check("dead_len_return", len, DC);
    check("dir_after_return", {30'd0, br_in[3:2]}, 32'd2);

    // Brake then drive: no dead time
    @(negedge clk); motor_in = 4'b1111;
    repeat (4) @(negedge clk);
    check("brake_pins", {28'd0, br_in}, 32'd15);
    check("brake_en", {30'd0, br_en}, 32'd3);
    motor_in = 4'b0110;
    seen = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); seen += int'(dead != 2'b00); end
    check("brake_to_run_nodead", seen, 0);
    check("brake_to_run_pins", {28'd0, br_in}, 32'd6);

    // Asynchronous reset mid-RUN
    repeat (20) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b0;
    #1 check("async_reset", {24'd0, br_in, br_en, dead}, 32'd0);
    @(negedge clk); motor_in = 4'b0101; motor_en = 2'b11;
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); seen += int'(dead != 2'b00); end
    check("restart_nodead", seen, 0);
    check("restart_pins", {28'd0, br_in}, 32'd5);

    // Randomized command sequences, checked every cycle by the model
    for (int s = 0; s < 36; s++) begin
      @(negedge clk);
      motor_in = 4'($urandom);
      motor_en = {($urandom_range(0, 5) != 0), ($urandom_range(0, 5) != 0)};
      if ($urandom_range(0, 1) == 0) n = $urandom_range(1, 12);
      else n = $urandom_range(200, 1300);
      if (s == 18) begin
        @(posedge clk); #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
      end
      repeat (n) @(negedge clk);
    end
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
